mips_data_memory_hs: RTL and testbench



---
 rtl/mips_data_memory_hs.sv | 240 ++++++++++++++++++++++++
 tb/tb_mips_data_memory_hs.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_memory_hs.sv
// ---------------------------------------------------------------------------
// mips_data_memory_hs
//
// Word-organised data RAM for the multicycle MIPS core. A request is taken
// through a valid/ready handshake, held for LATENCY cycles of wait states and
// answered through a second valid/ready handshake. Byte, halfword and word
// loads/stores are supported with little-endian lanes; loads are sign- or
// zero-extended. Misaligned, illegal-size and out-of-range requests are
// answered immediately with an error and never touch the array.
//
// Parameters
//   DEPTH      : number of 32-bit words (power of two, >= 2)
//   LATENCY    : cycles from request acceptance to response (>= 1)
//   ADDR_WIDTH : byte-address width (>= log2(DEPTH)+2)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : request present
//   req_ready  : block is idle and will accept a request
//   req_write  : 1 = store, 0 = load
//   req_size   : 00 byte, 01 half, 10 word, 11 illegal
//   req_signed : loads only, 1 = sign-extend, 0 = zero-extend
//   req_addr   : byte address
//   req_wdata  : right-justified store data
//   rsp_valid  : response present
//   rsp_ready  : consumer takes the response
//   rsp_rdata  : extended load data, 0 for stores and errors
//   rsp_error  : misaligned, illegal size or out of range
//   busy       : block is not idle
// ---------------------------------------------------------------------------
module mips_data_memory_hs #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH);
  // Counter only needs to hold LATENCY-1; keep at least one bit.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [31:0] mem [DEPTH];

  // Request fields captured at acceptance
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       lane_p0;
  logic [1:0]       size_p0;
  logic             signed_p0;
  logic             write_p0;
  logic [31:0]      wdata_p0;

  logic [31:0] rd_word;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic        commit;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Any of: illegal size, misaligned half/word, word index beyond DEPTH.
  function automatic logic req_err(input logic [1:0]            size,
                                   input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] hi;
    logic                  bad;
    hi  = addr >> (IDX_W + 2);
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad | (hi != '0);
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic [3:0] en;
    case (size)
      2'b00:   en = 4'b0001 << lane;
      2'b01:   en = lane[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  // Replicate right-justified store data across every lane so the byte
  // enables alone pick which bytes land in the word.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? 32'(b) : {24'd0, b};
      2'b01:   r = sgn ? 32'(h) : {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign rd_word = mem[idx_p0];
  assign be      = byte_en(size_p0, lane_p0);
  assign wlanes  = store_lanes(size_p0, wdata_p0);
  assign commit  = (state == ST_WAIT) && (cnt == '0);

  // -------------------------------------------------------------------------
  // Control FSM and registered handshake outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_err(req_size, req_addr)) begin
              // Rejected requests skip the wait states entirely.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end

        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= write_p0 ? 32'd0
                                  : load_extend(rd_word, size_p0, lane_p0, signed_p0);
          end
        end

        ST_RESP: begin
          // A request presented now is not taken; it waits for IDLE.
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Request capture (data only, no reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      idx_p0    <= req_addr[IDX_W+1:2];
      lane_p0   <= req_addr[1:0];
      size_p0   <= req_size;
      signed_p0 <= req_signed;
      write_p0  <= req_write;
      wdata_p0  <= req_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Array write, committed on the WAIT->RESP edge
  // -------------------------------------------------------------------------
  // Gating with rst_n drops a store whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (rst_n && commit && write_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx_p0][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_data_memory_hs.sv
// ---------------------------------------------------------------------------
// Testbench for mips_data_memory_hs. Four instances with LATENCY 2, 4, 1, 5
// share the clock; each has its own stimulus signals. A byte-level memory
// model per instance predicts load data, error flags and latency.
// ---------------------------------------------------------------------------
module tb_mips_data_memory_hs;

  localparam int DEPTH = 16;
  localparam int N     = 4;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 5;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n [N];
  logic        rv    [N];
  logic        rr    [N];
  logic        wr    [N];
  logic [1:0]  sz    [N];
  logic        sg    [N];
  logic [31:0] ad    [N];
  logic [31:0] wd    [N];
  logic        sv    [N];
  logic        srdy  [N];
  logic [31:0] rdat  [N];
  logic        serr  [N];
  logic        bsy   [N];

  logic [31:0] mm [N][DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mips_data_memory_hs #(
      .DEPTH     (DEPTH),
      .LATENCY   ((g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 5),
      .ADDR_WIDTH(32)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (rv[g]),
      .req_ready (rr[g]),
      .req_write (wr[g]),
      .req_size  (sz[g]),
      .req_signed(sg[g]),
      .req_addr  (ad[g]),
      .req_wdata (wd[g]),
      .rsp_valid (sv[g]),
      .rsp_ready (srdy[g]),
      .rsp_rdata (rdat[g]),
      .rsp_error (serr[g]),
      .busy      (bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference behaviour: bytes addressed little-endian inside each word.
  task automatic model(input int k, input logic w, input logic [1:0] s, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
    int          nb;
    int          off;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    err = (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0) ||
          (a / 4 >= DEPTH);
    rd = 32'd0;
    if (err) return;
    nb   = 1 << s;
    off  = int'(a % 4);
    word = mm[k][a / 4];
    if (w) begin
      for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = d[8*i +: 8];
      mm[k][a / 4] = word;
    end else begin
      v = word >> (8 * off);
      if (nb < 4) begin
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = v & mask;
        if (sgn && v[8*nb-1]) v = v | ~mask;
      end
      rd = v;
    end
  endtask

  task automatic issue(input int k, input logic w, input logic [1:0] s, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d);
    chk("req_ready_idle", 32'(rr[k]), 32'd1);
    wr[k] = w; sz[k] = s; sg[k] = sgn; ad[k] = a; wd[k] = d;
    rv[k] = 1'b1;
    @(posedge clk); #1;
    rv[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    while (sv[k] !== 1'b1 && lat < 40) begin
      chk("busy_wait", 32'(bsy[k]), 32'd1);
      chk("req_ready_wait", 32'(rr[k]), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_seen", 32'(sv[k]), 32'd1);
    rd = rdat[k];
    er = serr[k];
  endtask

  task automatic ack(input int k);
    srdy[k] = 1'b1;
    @(posedge clk); #1;
    srdy[k] = 1'b0;
    chk("rsp_drop", 32'(sv[k]), 32'd0);
    chk("idle_ready", 32'(rr[k]), 32'd1);
    chk("idle_busy", 32'(bsy[k]), 32'd0);
  endtask

  task automatic run(input int k, input logic w, input logic [1:0] s, input logic sgn,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat);
    logic [31:0] erd;
    logic        eerr;
    model(k, w, s, sgn, a, d, erd, eerr);
    issue(k, w, s, sgn, a, d);
    wait_rsp(k, rd, er, lat);
    chk("rdata", rd, erd);
    chk("error", 32'(er), 32'(eerr));
    chk("latency", 32'(lat), eerr ? 32'd0 : 32'(lat_of(k)));
    ack(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    logic [31:0] erd;
    logic        eerr;

    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; rv[k] = 1'b0; wr[k] = 1'b0; sz[k] = 2'd0; sg[k] = 1'b0;
      ad[k] = 32'd0; wd[k] = 32'd0; srdy[k] = 1'b0;
      for (int j = 0; j < DEPTH; j++) mm[k][j] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_req_ready", 32'(rr[k]), 32'd1);
      chk("rst_rsp_valid", 32'(sv[k]), 32'd0);
      chk("rst_rdata", rdat[k], 32'd0);
      chk("rst_error", 32'(serr[k]), 32'd0);
      chk("rst_busy", 32'(bsy[k]), 32'd0);
      rst_n[k] = 1'b1;
    end

    // Preload every word of instance 0 so sub-word stores merge into known data.
    for (int j = 0; j < DEPTH; j++) run(0, 1'b1, 2'd2, 1'b0, 32'(4 * j), $urandom, r, e, lat);

    // Word store/load and lane behaviour
    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat);
    chk("sw_rdata", r, 32'd0);
    chk("sw_latency", 32'(lat), 32'd2);
    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r, e, lat);
    chk("lw_10", r, 32'hDEADBEEF);
    run(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5, r, e, lat);
    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r, e, lat);
    chk("lw_after_sb", r, 32'hDEADA5EF);
    run(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, r, e, lat);
    chk("lb_11", r, 32'hFFFFFFA5);
    run(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, r, e, lat);
    chk("lbu_11", r, 32'h000000A5);
    run(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0, r, e, lat);
    chk("lh_12", r, 32'hFFFFDEAD);
    run(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, r, e, lat);
    chk("lhu_12", r, 32'h0000DEAD);

    // Error cases answer one cycle after acceptance with no array access
    run(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'd0, r, e, lat);
    chk("err_lw13", 32'(e), 32'd1);
    run(0, 1'b1, 2'd1, 1'b0, 32'h11, 32'h0000FFFF, r, e, lat);
    chk("err_sh11", 32'(e), 32'd1);
    run(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, r, e, lat);
    chk("err_size3", 32'(e), 32'd1);
    run(0, 1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'hFFFFFFFF, r, e, lat);
    chk("err_range", 32'(e), 32'd1);
    chk("err_range_lat", 32'(lat), 32'd0);
    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r, e, lat);
    chk("lw_after_err", r, 32'hDEADA5EF);

    // Backpressure: response held, competing request ignored until IDLE
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    wait_rsp(0, r, e, lat);
    chk("bp_rdata", r, 32'hDEADA5EF);
    wr[0] = 1'b1; sz[0] = 2'd2; sg[0] = 1'b0; ad[0] = 32'h0; wd[0] = 32'hBAD0BAD0;
    rv[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(sv[0]), 32'd1);
      chk("bp_rdata_hold", rdat[0], 32'hDEADA5EF);
      chk("bp_req_ready", 32'(rr[0]), 32'd0);
    end
    srdy[0] = 1'b1;
    @(posedge clk); #1;
    srdy[0] = 1'b0;
    chk("bp_release_valid", 32'(sv[0]), 32'd0);
    chk("bp_release_ready", 32'(rr[0]), 32'd1);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("bp_accept", 32'(rr[0]), 32'd0);
    chk("bp_accept_busy", 32'(bsy[0]), 32'd1);
    model(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'hBAD0BAD0, erd, eerr);
    wait_rsp(0, r, e, lat);
    chk("bp_store_rdata", r, erd);
    chk("bp_store_error", 32'(e), 32'(eerr));
    chk("bp_store_lat", 32'(lat), 32'd2);
    ack(0);
    run(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, r, e, lat);
    chk("bp_store_seen", r, 32'hBAD0BAD0);

    // Randomized mix, including misaligned and out-of-range addresses
    for (int i = 0; i < 200; i++) begin
      run(0, 1'($urandom), 2'($urandom), 1'($urandom),
          32'($urandom_range(0, 4 * DEPTH + 7)), $urandom, r, e, lat);
    end

    // Reset during WAIT drops the pending store (LATENCY=4 instance)
    run(1, 1'b1, 2'd2, 1'b0, 32'h20 % (4 * DEPTH), 32'd0, r, e, lat);
    issue(1, 1'b1, 2'd2, 1'b0, 32'h20 % (4 * DEPTH), 32'h12345678);
    @(posedge clk); #1;
    chk("mid_busy", 32'(bsy[1]), 32'd1);
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    chk("mid_rst_ready", 32'(rr[1]), 32'd1);
    chk("mid_rst_valid", 32'(sv[1]), 32'd0);
    chk("mid_rst_rdata", rdat[1], 32'd0);
    chk("mid_rst_error", 32'(serr[1]), 32'd0);
    chk("mid_rst_busy", 32'(bsy[1]), 32'd0);
    run(1, 1'b0, 2'd2, 1'b0, 32'h20 % (4 * DEPTH), 32'd0, r, e, lat);
    chk("mid_rst_dropped", r, 32'd0);

    // Latency sweep on LATENCY=1 and LATENCY=5 instances
    run(2, 1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D, r, e, lat);
    chk("lat1_store", 32'(lat), 32'd1);
    run(2, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, r, e, lat);
    chk("lat1_load", r, 32'hCAFEF00D);
    run(3, 1'b1, 2'd1, 1'b0, 32'h6, 32'h00008001, r, e, lat);
    chk("lat5_store", 32'(lat), 32'd5);
    run(3, 1'b0, 2'd1, 1'b1, 32'h6, 32'd0, r, e, lat);
    chk("lat5_lh", r, 32'hFFFF8001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
